lif_array_tm: RTL and testbench

LIF_ARRAY_TM -- requirements
Module: lif_array_tm

---
 rtl/lif_array_tm.sv | 124 ++++++++++++
 tb/tb_lif_array_tm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lif_array_tm.sv
// Array of leaky integrate-and-fire neurons sharing one update datapath.
// One channel update per cycle, result registered one cycle later.
module lif_array_tm #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int REF_BITS = 3,
  parameter int CH_BITS  = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                cur_valid,
  input  logic [CH_BITS-1:0]  cur_ch,
  input  logic [WIDTH-1:0]    current,
  input  logic [WIDTH-1:0]    threshold,
  input  logic [2:0]          leak_shift,
  input  logic                reset_mode,
  input  logic [REF_BITS-1:0] refrac_len,
  output logic                out_valid,
  output logic [CH_BITS-1:0]  out_ch,
  output logic                spike,
  output logic [WIDTH-1:0]    state,
  output logic [15:0]         spike_cnt
);

  localparam logic [CH_BITS:0] NCH_W = (CH_BITS+1)'(N_CH);

  logic [WIDTH-1:0]    u_q [N_CH];
  logic [REF_BITS-1:0] r_q [N_CH];

  logic                out_valid_q;
  logic [CH_BITS-1:0]  out_ch_q;
  logic                spike_q;
  logic [WIDTH-1:0]    state_q;
  logic [15:0]         cnt_q;

  logic                accept;
  logic [WIDTH-1:0]    cur_u;
  logic [REF_BITS-1:0] cur_r;
  logic [WIDTH-1:0]    leak;
  logic [WIDTH-1:0]    dec;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    sat;
  logic                fire;
  logic [WIDTH-1:0]    u_d;
  logic [REF_BITS-1:0] r_d;

  always_comb begin
    accept = cur_valid && !clr && ({1'b0, cur_ch} < NCH_W);
    cur_u  = '0;
    cur_r  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (CH_BITS'(i) == cur_ch) begin
        cur_u = u_q[i];
        cur_r = r_q[i];
      end
    end
  end

  // Refractory channels decay but ignore their input current.
  always_comb begin
    leak = (leak_shift == 3'd0) ? '0 : (cur_u >> leak_shift);
    dec  = cur_u - leak;
    sum  = {1'b0, dec} +
           {1'b0, (cur_r == '0) ? current : '0};
    sat  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    fire = (cur_r == '0) && (threshold != '0) &&
           (sat >= threshold);
    if (fire) begin
      u_d = reset_mode ? '0 : sat - threshold;
      r_d = refrac_len;
    end else begin
      u_d = sat;
      r_d = (cur_r == '0) ? '0 : cur_r - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        u_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < N_CH; i++) begin
        u_q[i] <= '0;
        r_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N_CH; i++) begin
        if (CH_BITS'(i) == cur_ch) begin
          u_q[i] <= u_d;
          r_q[i] <= r_d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      spike_q     <= 1'b0;
      state_q     <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        out_ch_q <= cur_ch;
        spike_q  <= fire;
        state_q  <= u_d;
        if (fire && cnt_q != 16'hFFFF)
          cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign spike     = spike_q;
  assign state     = state_q;
  assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_lif_array_tm.sv
// Directed bench for lif_array_tm: reset, leak, saturation,
// refractory, interleave/bounds and clear behaviour.
module tb_lif_array_tm;

  localparam int N_CH    = 4;
  localparam int WIDTH   = 8;
  localparam int REF_B   = 3;
  localparam int CH_BITS = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clr;
  logic               cur_valid;
  logic [CH_BITS-1:0] cur_ch;
  logic [WIDTH-1:0]   current;
  logic [WIDTH-1:0]   threshold;
  logic [2:0]         leak_shift;
  logic               reset_mode;
  logic [REF_B-1:0]   refrac_len;
  logic               out_valid;
  logic [CH_BITS-1:0] out_ch;
  logic               spike;
  logic [WIDTH-1:0]   state;
  logic [15:0]        spike_cnt;

  int n_run  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  lif_array_tm #(
    .N_CH(N_CH), .WIDTH(WIDTH),
    .REF_BITS(REF_B), .CH_BITS(CH_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .cur_valid(cur_valid), .cur_ch(cur_ch),
    .current(current), .threshold(threshold),
    .leak_shift(leak_shift), .reset_mode(reset_mode),
    .refrac_len(refrac_len), .out_valid(out_valid),
    .out_ch(out_ch), .spike(spike), .state(state),
    .spike_cnt(spike_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input int thr, input int ls,
                     input int rm, input int rl);
    threshold  = WIDTH'(thr);
    leak_shift = 3'(ls);
    reset_mode = rm[0];
    refrac_len = REF_B'(rl);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic upd(input string tag, input int ch,
                     input int cur, input int vld,
                     input int spk, input int st);
    cur_valid = 1'b1;
    cur_ch    = CH_BITS'(ch);
    current   = WIDTH'(cur);
    @(negedge clk);
    cur_valid = 1'b0;
    check({tag, ".valid"}, 32'(out_valid), 32'(vld));
    if (vld != 0) begin
      exp_cnt += spk;
      check({tag, ".ch"}, 32'(out_ch), 32'(ch));
      check({tag, ".spike"}, 32'(spike), 32'(spk));
      check({tag, ".state"}, 32'(state), 32'(st));
      check({tag, ".cnt"}, 32'(spike_cnt), 32'(exp_cnt));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    cur_valid = 1'b0;
    cur_ch = '0;
    current = '0;
    cfg(0, 0, 0, 0);
    #12;
    check("rst.valid", 32'(out_valid), 0);
    check("rst.state", 32'(state), 0);
    check("rst.cnt", 32'(spike_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-stream reset
    cfg(3, 0, 1, 0);
    upd("pre", 1, 5, 1, 1, 0);
    cur_valid = 1'b1;
    cur_ch = 3'd0;
    current = 8'd7;
    #2 rst_n = 1'b0;
    #1;
    check("mid.valid", 32'(out_valid), 0);
    check("mid.spike", 32'(spike), 0);
    check("mid.state", 32'(state), 0);
    check("mid.ch", 32'(out_ch), 0);
    check("mid.cnt", 32'(spike_cnt), 0);
    exp_cnt = 0;
    @(negedge clk);
    cur_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cfg(0, 0, 0, 0);
    upd("post", 0, 5, 1, 0, 5);

    // Clear with a simultaneous update
    clr = 1'b1;
    cur_valid = 1'b1;
    cur_ch = 3'd0;
    current = 8'd9;
    @(negedge clk);
    clr = 1'b0;
    cur_valid = 1'b0;
    check("clr.valid", 32'(out_valid), 0);
    check("clr.cnt", 32'(spike_cnt), 32'(exp_cnt));
    upd("clr.u0", 0, 0, 1, 0, 0);

    // Leak / integrate
    cfg(100, 2, 0, 0);
    upd("leak1", 0, 40, 1, 0, 40);
    upd("leak2", 0, 40, 1, 0, 70);
    upd("leak3", 0, 40, 1, 0, 93);
    upd("leak4", 0, 40, 1, 1, 10);

    // Saturation
    cfg(255, 0, 1, 0);
    upd("sat1", 1, 200, 1, 0, 200);
    upd("sat2", 1, 100, 1, 1, 0);

    // Refractory
    cfg(10, 0, 0, 2);
    upd("ref1", 2, 20, 1, 1, 10);
    upd("ref2", 2, 20, 1, 0, 10);
    upd("ref3", 2, 20, 1, 0, 10);
    upd("ref4", 2, 20, 1, 1, 20);

    // Interleave and out-of-range channel
    cfg(0, 0, 0, 0);
    upd("il0a", 0, 1, 1, 0, 11);
    upd("il3a", 3, 3, 1, 0, 3);
    upd("il5",  5, 9, 0, 0, 0);
    upd("il0b", 0, 1, 1, 0, 12);
    upd("il3b", 3, 3, 1, 0, 6);
    upd("il3c", 3, 3, 1, 0, 9);
    upd("keep1", 1, 0, 1, 0, 0);
    upd("keep2", 2, 0, 1, 0, 20);

    // Clear again: counter must survive
    clr = 1'b1;
    cur_valid = 1'b1;
    cur_ch = 3'd3;
    current = 8'd50;
    @(negedge clk);
    clr = 1'b0;
    cur_valid = 1'b0;
    check("clr2.valid", 32'(out_valid), 0);
    check("clr2.cnt", 32'(spike_cnt), 4);
    upd("clr2.u3", 3, 0, 1, 0, 0);
    upd("clr2.u2", 2, 0, 1, 0, 0);
    upd("clr2.u0", 0, 0, 1, 0, 0);

    @(negedge clk);
    check("idle.valid", 32'(out_valid), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
